// File: rtl/spirose_rgb_pkg.sv
// Shared geometry, output word type and transmit FSM encoding for the
// parallel RGB stream.
package spirose_rgb_pkg;

  localparam int unsigned UBLOCK_W = 8;
  localparam int unsigned UBLOCK_H = 16;
  localparam int unsigned BLOCKS_X = 5;
  localparam int unsigned BLOCKS_Y = 3;
  localparam int unsigned H_ACTIVE = UBLOCK_W * BLOCKS_X;
  localparam int unsigned V_ACTIVE = UBLOCK_H * BLOCKS_Y;

  typedef struct packed {
    logic [23:0] rgb;
    logic        hsync;
    logic        vsync;
  } rgb_word_t;

  typedef enum logic [1:0] {IDLE, VBLANK, ACTIVE, HBLANK} tx_state_t;

  // Byte swap so the receiver's unpacking yields the original pixel.
  function automatic logic [23:0] pack_rgb(input logic [23:0] d);
    return {d[7:0], d[15:8], d[23:16]};
  endfunction

endpackage

// File: rtl/rgb_stream_tx.sv
// Transmit end of the parallel RGB stream: serialises valid/ready pixels into
// framed {rgb, hsync, vsync} words written to the CDC FIFO.
module rgb_stream_tx #(
  parameter int unsigned H_ACTIVE = spirose_rgb_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE = spirose_rgb_pkg::V_ACTIVE,
  parameter int unsigned H_BLANK  = 4,
  parameter int unsigned V_BLANK  = 8
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        enable,
  input  logic [23:0] in_data,
  input  logic        in_sof,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        fifo_full,
  output logic        fifo_wr,
  output logic [23:0] rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_done,
  output logic        sync_err
);
  import spirose_rgb_pkg::*;

  localparam int unsigned MAX_BLANK = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int unsigned PX_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned LN_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int unsigned BL_W = (MAX_BLANK > 1) ? $clog2(MAX_BLANK) : 1;

  tx_state_t       state, state_nxt;
  logic [PX_W-1:0] px;
  logic [LN_W-1:0] line;
  logic [BL_W-1:0] blank;
  rgb_word_t       out_word, word_nxt;
  logic            accept, at_origin, discard;
  logic            last_px, last_line, last_vblank, last_hblank;
  logic            word_en, fd_nxt, se_nxt;

  assign in_ready    = (state == ACTIVE) & ~fifo_full;
  assign accept      = in_valid & in_ready;
  assign at_origin   = (px == '0) && (line == '0);
  assign discard     = accept & at_origin & ~in_sof;
  assign last_px     = (px == PX_W'(H_ACTIVE - 1));
  assign last_line   = (line == LN_W'(V_ACTIVE - 1));
  assign last_vblank = (blank == BL_W'(V_BLANK - 1));
  assign last_hblank = (blank == BL_W'(H_BLANK - 1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  // A blocked FIFO holds the final word of a state, so the state holds too.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (enable) state_nxt = VBLANK;
      VBLANK: if (!fifo_full && last_vblank) state_nxt = ACTIVE;
      ACTIVE: if (accept && !discard && last_px) state_nxt = HBLANK;
      HBLANK: if (!fifo_full && last_hblank) begin
        if (!last_line)  state_nxt = ACTIVE;
        else if (enable) state_nxt = VBLANK;
        else             state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pixel at the origin without sof is dropped; sof elsewhere is only flagged.
  always_comb begin
    word_en  = 1'b0;
    word_nxt = '0;
    fd_nxt   = 1'b0;
    se_nxt   = 1'b0;
    unique case (state)
      VBLANK: word_en = ~fifo_full;
      ACTIVE: begin
        se_nxt         = accept & (at_origin ^ in_sof);
        word_en        = accept & ~discard;
        word_nxt.rgb   = pack_rgb(in_data);
        word_nxt.hsync = 1'b1;
        word_nxt.vsync = 1'b1;
        fd_nxt         = word_en & last_px & last_line;
      end
      HBLANK: begin
        word_en        = ~fifo_full;
        word_nxt.vsync = 1'b1;
      end
      default: word_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      px    <= '0;
      line  <= '0;
      blank <= '0;
    end else begin
      unique case (state)
        VBLANK: if (!fifo_full) blank <= last_vblank ? '0 : blank + 1'b1;
        ACTIVE: if (word_en) px <= last_px ? '0 : px + 1'b1;
        HBLANK: if (!fifo_full) begin
          if (last_hblank) begin
            blank <= '0;
            line  <= last_line ? '0 : line + 1'b1;
          end else begin
            blank <= blank + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fifo_wr    <= 1'b0;
      out_word   <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      fifo_wr    <= word_en;
      frame_done <= fd_nxt;
      sync_err   <= se_nxt;
      if (word_en) out_word <= word_nxt;
    end
  end

  assign rgb   = out_word.rgb;
  assign hsync = out_word.hsync;
  assign vsync = out_word.vsync;

endmodule

// File: tb/tb_rgb_stream_tx.sv
// Scoreboard bench for rgb_stream_tx: a source model feeds pixels, expected
// words are queued alongside and popped as the DUT writes to the FIFO.
module tb_rgb_stream_tx;

  localparam int H_ACT = 40;
  localparam int V_ACT = 48;
  localparam int H_BLK = 4;
  localparam int V_BLK = 8;
  localparam int FRAME_WORDS = V_ACT * (H_ACT + H_BLK) + V_BLK;

  typedef struct {
    logic [23:0] rgb;
    logic        h;
    logic        v;
    logic        fd;
  } exp_t;

  typedef struct {
    logic [23:0] d;
    logic        sof;
  } src_t;

  logic        clk = 1'b0;
  logic        nrst, enable, in_sof, in_valid, fifo_full;
  logic [23:0] in_data;
  logic        in_ready, fifo_wr, hsync, vsync, frame_done, sync_err;
  logic [23:0] rgb;

  exp_t exp_q[$];
  src_t src_q[$];

  int checks = 0, errors = 0;
  int wr_cnt = 0, pix_cnt = 0, fd_cnt = 0, se_cnt = 0;
  int valid_mode = 0;
  bit full_rand = 1'b0;
  bit took = 1'b0;

  always #5 clk = ~clk;

  rgb_stream_tx #(
    .H_ACTIVE(H_ACT),
    .V_ACTIVE(V_ACT),
    .H_BLANK (H_BLK),
    .V_BLANK (V_BLK)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .enable    (enable),
    .in_data   (in_data),
    .in_sof    (in_sof),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fifo_full (fifo_full),
    .fifo_wr   (fifo_wr),
    .rgb       (rgb),
    .hsync     (hsync),
    .vsync     (vsync),
    .frame_done(frame_done),
    .sync_err  (sync_err)
  );

  function automatic logic [23:0] swap_bytes(input logic [23:0] d);
    return {d[7:0], d[15:8], d[23:16]};
  endfunction

  // Handshake sampled late in the cycle, after any negedge-driven stalls.
  initial forever begin
    @(negedge clk);
    #2;
    took = in_valid & in_ready & nrst;
  end

  initial begin
    src_t s;
    bit   phase;
    bit   show;
    phase = 1'b0;
    in_valid = 1'b0; in_sof = 1'b0; in_data = '0; fifo_full = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (took && src_q.size() > 0) s = src_q.pop_front();
      took = 1'b0;
      if (full_rand) fifo_full = ($urandom_range(0, 3) == 0);
      phase = ~phase;
      show = (src_q.size() > 0) &&
             ((valid_mode == 0) || (valid_mode == 1 && phase) ||
              (valid_mode == 2 && $urandom_range(0, 2) != 0));
      in_valid = show;
      if (show) begin
        in_data = src_q[0].d;
        in_sof  = src_q[0].sof;
      end else begin
        in_sof = 1'b0;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (fifo_wr === 1'b1) begin
        wr_cnt++;
        if (hsync && vsync) pix_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got rgb=%06h h=%b v=%b, required no write",
                   rgb, hsync, vsync);
        end else begin
          e = exp_q.pop_front();
          if ({rgb, hsync, vsync, frame_done} !== {e.rgb, e.h, e.v, e.fd}) begin
            errors++;
            $display("FAIL word_%0d: got rgb=%06h h=%b v=%b fd=%b, required rgb=%06h h=%b v=%b fd=%b",
                     wr_cnt, rgb, hsync, vsync, frame_done, e.rgb, e.h, e.v, e.fd);
          end
        end
      end else if (frame_done !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL frame_done_no_write: got frame_done=%b, required 0", frame_done);
      end
      if (frame_done === 1'b1) fd_cnt++;
      if (sync_err === 1'b1) se_cnt++;
    end
  end

  task automatic push_frame(input bit fixed, input int sof_extra);
    logic [23:0] d;
    for (int i = 0; i < V_BLK; i++) exp_q.push_back('{24'h0, 1'b0, 1'b0, 1'b0});
    for (int l = 0; l < V_ACT; l++) begin
      for (int p = 0; p < H_ACT; p++) begin
        d = fixed ? 24'h112233 : 24'($urandom());
        src_q.push_back('{d, (l == 0 && p == 0) || (l * H_ACT + p == sof_extra)});
        exp_q.push_back('{swap_bytes(d), 1'b1, 1'b1, (l == V_ACT - 1 && p == H_ACT - 1)});
      end
      for (int b = 0; b < H_BLK; b++) exp_q.push_back('{24'h0, 1'b0, 1'b1, 1'b0});
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d words pending after %0d cycles, required 0",
               name, exp_q.size(), n);
    end
  endtask

  // Keeps enable high until the given line has started, then lets the frame finish.
  task automatic run_frame(input string name, input int start_pix, input int drop_line,
                           input int budget);
    int n = 0;
    enable = 1'b1;
    while (pix_cnt < start_pix + drop_line * H_ACT + 1 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    enable = 1'b0;
    wait_drain(name, budget);
  endtask

  task automatic check_end(input string name, input int wr0, input int fd0, input int se0,
                           input int frames, input int se_exp);
    repeat (16) @(negedge clk);
    #1;
    checks++;
    if (wr_cnt - wr0 !== frames * FRAME_WORDS) begin
      errors++;
      $display("FAIL %s_writes: got %0d, required %0d", name, wr_cnt - wr0, frames * FRAME_WORDS);
    end
    checks++;
    if (fd_cnt - fd0 !== frames) begin
      errors++;
      $display("FAIL %s_frame_done: got %0d, required %0d", name, fd_cnt - fd0, frames);
    end
    checks++;
    if (se_cnt - se0 !== se_exp) begin
      errors++;
      $display("FAIL %s_sync_err: got %0d, required %0d", name, se_cnt - se0, se_exp);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_ready: got in_ready=%b, required 0", name, in_ready);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({fifo_wr, rgb, hsync, vsync, frame_done, sync_err, in_ready} !== 30'h0) begin
      errors++;
      $display("FAIL reset_outputs: got wr=%b rgb=%06h h=%b v=%b fd=%b se=%b rdy=%b, required all 0",
               fifo_wr, rgb, hsync, vsync, frame_done, sync_err, in_ready);
    end
    nrst = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if ({fifo_wr, in_ready, wr_cnt} !== {1'b0, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL idle_no_enable: got wr=%b rdy=%b writes=%0d, required 0 0 0",
               fifo_wr, in_ready, wr_cnt);
    end
  endtask

  task automatic test_basic();
    int w0 = wr_cnt, f0 = fd_cnt, s0 = se_cnt;
    push_frame(1'b1, -1);
    run_frame("basic", pix_cnt, V_ACT - 1, 5000);
    check_end("basic", w0, f0, s0, 1, 0);
  endtask

  task automatic test_fifo_stall();
    int w0 = wr_cnt, f0 = fd_cnt, s0 = se_cnt, p0 = pix_cnt, n = 0;
    push_frame(1'b0, -1);
    enable = 1'b1;
    while (pix_cnt < p0 + 17 && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    fifo_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({fifo_wr, in_ready} !== 2'b00) begin
        errors++;
        $display("FAIL stall_cycle_%0d: got wr=%b rdy=%b, required 0 0", i, fifo_wr, in_ready);
      end
    end
    fifo_full = 1'b0;
    run_frame("stall", p0, V_ACT - 1, 5000);
    check_end("stall", w0, f0, s0, 1, 0);
  endtask

  task automatic test_valid_toggle();
    int w0 = wr_cnt, f0 = fd_cnt, s0 = se_cnt;
    valid_mode = 1;
    push_frame(1'b0, -1);
    run_frame("toggle", pix_cnt, V_ACT - 1, 9000);
    valid_mode = 0;
    check_end("toggle", w0, f0, s0, 1, 0);
  endtask

  task automatic test_sync();
    int w0 = wr_cnt, f0 = fd_cnt, s0 = se_cnt;
    for (int i = 0; i < 3; i++) src_q.push_back('{24'($urandom()), 1'b0});
    push_frame(1'b0, 2 * H_ACT + 5);
    run_frame("sync", pix_cnt, V_ACT - 1, 5000);
    check_end("sync", w0, f0, s0, 1, 4);
  endtask

  task automatic test_enable_drop();
    int w0 = wr_cnt, f0 = fd_cnt, s0 = se_cnt;
    push_frame(1'b0, -1);
    run_frame("endrop", pix_cnt, 20, 5000);
    check_end("endrop", w0, f0, s0, 1, 0);
    w0 = wr_cnt; f0 = fd_cnt; s0 = se_cnt;
    push_frame(1'b0, -1);
    run_frame("reenable", pix_cnt, 1, 5000);
    check_end("reenable", w0, f0, s0, 1, 0);
  endtask

  task automatic test_back_to_back();
    int w0 = wr_cnt, f0 = fd_cnt, s0 = se_cnt;
    push_frame(1'b0, -1);
    push_frame(1'b0, -1);
    run_frame("b2b", pix_cnt, V_ACT + 5, 10000);
    check_end("b2b", w0, f0, s0, 2, 0);
  endtask

  task automatic test_random_stalls();
    int w0 = wr_cnt, f0 = fd_cnt, s0 = se_cnt;
    valid_mode = 2;
    full_rand = 1'b1;
    push_frame(1'b0, -1);
    run_frame("random", pix_cnt, V_ACT - 1, 20000);
    full_rand = 1'b0;
    fifo_full = 1'b0;
    valid_mode = 0;
    check_end("random", w0, f0, s0, 1, 0);
  endtask

  task automatic test_async_reset();
    int w0, f0, s0, p0 = pix_cnt, n = 0;
    push_frame(1'b0, -1);
    enable = 1'b1;
    while (pix_cnt < p0 + 100 && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    nrst = 1'b0;
    enable = 1'b0;
    src_q.delete();
    exp_q.delete();
    #1;
    checks++;
    if ({fifo_wr, rgb, hsync, vsync, frame_done, sync_err, in_ready} !== 30'h0) begin
      errors++;
      $display("FAIL async_reset_outputs: got wr=%b rgb=%06h h=%b v=%b fd=%b se=%b rdy=%b, required all 0",
               fifo_wr, rgb, hsync, vsync, frame_done, sync_err, in_ready);
    end
    repeat (3) @(negedge clk);
    #1;
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    w0 = wr_cnt; f0 = fd_cnt; s0 = se_cnt;
    push_frame(1'b0, -1);
    run_frame("post_reset", pix_cnt, 1, 5000);
    check_end("post_reset", w0, f0, s0, 1, 0);
  endtask

  initial begin
    nrst = 1'b0;
    enable = 1'b0;
    test_reset();
    test_basic();
    test_fifo_stall();
    test_valid_toggle();
    test_sync();
    test_enable_drop();
    test_back_to_back();
    test_random_stalls();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
